// File: rtl/sys_timer_host.sv
// Avalon-MM master that programs and services the interval timer autonomously:
// configures period/control, acknowledges timeouts, counts ticks and snapshots the counter.
module sys_timer_host #(
  parameter int          TICK_WIDTH  = 32,
  parameter logic [31:0] INIT_PERIOD = 32'd49999,
  parameter bit          AUTO_START  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [2:0]            av_address,
  output logic                  av_chipselect,
  output logic                  av_write_n,
  output logic [15:0]           av_writedata,
  input  logic [15:0]           av_readdata,
  input  logic                  timer_irq,
  input  logic                  cfg_req,
  input  logic [31:0]           cfg_period,
  input  logic                  cfg_cont,
  input  logic                  cfg_irq_en,
  input  logic                  stop_req,
  input  logic                  snap_req,
  input  logic                  clear_ticks,
  output logic                  busy,
  output logic                  cfg_done,
  output logic                  snap_valid,
  output logic [31:0]           snap_value,
  output logic                  tick,
  output logic [TICK_WIDTH-1:0] tick_count
);

  typedef enum logic [3:0] {
    IDLE, ACK, STOP,
    CFG_STOP, CFG_PL, CFG_PH, CFG_CTRL,
    SNAP_WR, SNAP_RL, SNAP_RH, SNAP_CAP
  } state_t;

  localparam logic [15:0] CTRL_STOP = 16'h0008;
  // Pending-bit order: 0 cfg, 1 stop, 2 snap
  localparam logic [2:0]  PEND_RST  = {2'b00, AUTO_START};

  state_t state_reg, state_next;

  logic [2:0]  req_vec, clr_vec, pend_reg;
  logic [31:0] cfg_period_reg, act_period_reg;
  logic        cfg_cont_reg, cfg_irq_en_reg, act_cont_reg, act_irq_en_reg;

  logic [2:0]  addr_next;
  logic        cs_next, write_n_next;
  logic [15:0] wdata_next;

  assign req_vec = {snap_req, stop_req, cfg_req};
  assign clr_vec = {state_next == SNAP_WR, state_next == STOP, state_next == CFG_STOP};

  // Requests are sticky until their sequence starts; a new request on the start edge re-arms.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_pend
      logic pend_bit_reg;
      always_ff @(posedge clk) begin
        if (reset) pend_bit_reg <= PEND_RST[gi];
        else       pend_bit_reg <= req_vec[gi] | (pend_bit_reg & ~clr_vec[gi]);
      end
      assign pend_reg[gi] = pend_bit_reg;
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (timer_irq)        state_next = ACK;
        else if (pend_reg[1]) state_next = STOP;
        else if (pend_reg[0]) state_next = CFG_STOP;
        else if (pend_reg[2]) state_next = SNAP_WR;
      end
      CFG_STOP: state_next = CFG_PL;
      CFG_PL:   state_next = CFG_PH;
      CFG_PH:   state_next = CFG_CTRL;
      SNAP_WR:  state_next = SNAP_RL;
      SNAP_RL:  state_next = SNAP_RH;
      SNAP_RH:  state_next = SNAP_CAP;
      default:  state_next = IDLE;
    endcase
  end

  // Bus signals are decoded from the next state so they are registered into the state's own cycle.
  always_comb begin
    addr_next    = 3'd0;
    cs_next      = 1'b0;
    write_n_next = 1'b1;
    wdata_next   = 16'h0000;
    case (state_next)
      ACK: begin
        cs_next = 1'b1; write_n_next = 1'b0;
      end
      STOP, CFG_STOP: begin
        cs_next = 1'b1; write_n_next = 1'b0; addr_next = 3'd1; wdata_next = CTRL_STOP;
      end
      CFG_PL: begin
        cs_next = 1'b1; write_n_next = 1'b0; addr_next = 3'd2; wdata_next = act_period_reg[15:0];
      end
      CFG_PH: begin
        cs_next = 1'b1; write_n_next = 1'b0; addr_next = 3'd3; wdata_next = act_period_reg[31:16];
      end
      CFG_CTRL: begin
        cs_next = 1'b1; write_n_next = 1'b0; addr_next = 3'd1;
        wdata_next = {12'b0, 1'b0, 1'b1, act_cont_reg, act_irq_en_reg};
      end
      SNAP_WR: begin
        cs_next = 1'b1; write_n_next = 1'b0; addr_next = 3'd4;
      end
      SNAP_RL: begin
        cs_next = 1'b1; addr_next = 3'd4;
      end
      SNAP_RH: begin
        cs_next = 1'b1; addr_next = 3'd5;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      cfg_period_reg <= INIT_PERIOD;
      cfg_cont_reg   <= 1'b1;
      cfg_irq_en_reg <= 1'b1;
      act_period_reg <= INIT_PERIOD;
      act_cont_reg   <= 1'b1;
      act_irq_en_reg <= 1'b1;
      av_address     <= 3'd0;
      av_chipselect  <= 1'b0;
      av_write_n     <= 1'b1;
      av_writedata   <= 16'h0000;
      busy           <= 1'b0;
      cfg_done       <= 1'b0;
      snap_valid     <= 1'b0;
      snap_value     <= 32'h0;
      tick           <= 1'b0;
      tick_count     <= '0;
    end else begin
      state_reg <= state_next;
      if (cfg_req) begin
        cfg_period_reg <= cfg_period;
        cfg_cont_reg   <= cfg_cont;
        cfg_irq_en_reg <= cfg_irq_en;
      end
      // Working copy keeps a running sequence consistent if cfg_req arrives mid-sequence.
      if (state_next == CFG_STOP) begin
        act_period_reg <= cfg_period_reg;
        act_cont_reg   <= cfg_cont_reg;
        act_irq_en_reg <= cfg_irq_en_reg;
      end
      av_address    <= addr_next;
      av_chipselect <= cs_next;
      av_write_n    <= write_n_next;
      av_writedata  <= wdata_next;
      busy          <= (state_next != IDLE);
      tick          <= (state_reg == ACK);
      cfg_done      <= (state_reg == CFG_CTRL);
      snap_valid    <= (state_reg == SNAP_CAP);
      // Slave readdata trails the address by one cycle.
      if (state_reg == SNAP_RH)  snap_value[15:0]  <= av_readdata;
      if (state_reg == SNAP_CAP) snap_value[31:16] <= av_readdata;
      if (clear_ticks)             tick_count <= '0;
      else if (state_reg == ACK)   tick_count <= tick_count + TICK_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_sys_timer_host.sv
// Bench for sys_timer_host: behavioural timer slave, directed corner cases,
// table vectors and randomized request mixes checked against a transaction-level model.
module tb_sys_timer_host;

  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [2:0]    av_address;
  logic          av_chipselect, av_write_n;
  logic [15:0]   av_writedata;
  logic [15:0]   av_readdata;
  logic          timer_irq = 1'b0;
  logic          cfg_req = 1'b0;
  logic [31:0]   cfg_period = 32'h0;
  logic          cfg_cont = 1'b0, cfg_irq_en = 1'b0;
  logic          stop_req = 1'b0, snap_req = 1'b0, clear_ticks = 1'b0;
  logic          busy, cfg_done, snap_valid, tick;
  logic [31:0]   snap_value;
  logic [TW-1:0] tick_count;

  always #5 clk = ~clk;

  sys_timer_host #(.TICK_WIDTH(TW), .INIT_PERIOD(32'd49999), .AUTO_START(1'b1)) dut (
    .clk(clk), .reset(reset),
    .av_address(av_address), .av_chipselect(av_chipselect), .av_write_n(av_write_n),
    .av_writedata(av_writedata), .av_readdata(av_readdata), .timer_irq(timer_irq),
    .cfg_req(cfg_req), .cfg_period(cfg_period), .cfg_cont(cfg_cont), .cfg_irq_en(cfg_irq_en),
    .stop_req(stop_req), .snap_req(snap_req), .clear_ticks(clear_ticks),
    .busy(busy), .cfg_done(cfg_done), .snap_valid(snap_valid), .snap_value(snap_value),
    .tick(tick), .tick_count(tick_count)
  );

  // Timer slave: writing addr 4 latches the live counter, writing addr 0 drops the irq.
  logic [15:0] sregs [0:7];
  logic [31:0] snap_src = 32'h0;
  logic        irq_raise = 1'b0;

  always @(posedge clk) begin
    if (av_chipselect === 1'b1 && av_write_n === 1'b0) begin
      if (av_address == 3'd4) begin
        sregs[4] <= snap_src[15:0];
        sregs[5] <= snap_src[31:16];
      end else begin
        sregs[av_address] <= av_writedata;
      end
    end
    if (av_chipselect === 1'b1 && av_write_n === 1'b0 && av_address == 3'd0) timer_irq <= 1'b0;
    else if (irq_raise) timer_irq <= 1'b1;
    if (av_chipselect === 1'b1 && av_write_n === 1'b1) av_readdata <= sregs[av_address];
  end

  // Monitor
  logic [18:0] wr_log [$];
  int   cyc_cnt = 0, n_tick = 0, n_done = 0, n_sv = 0, n_busy = 0;
  int   busy_rise_cyc = 0, sv_cyc = 0;
  logic busy_d = 1'b0;

  always @(negedge clk) begin
    if (av_chipselect === 1'b1 && av_write_n === 1'b0) wr_log.push_back({av_address, av_writedata});
    cyc_cnt <= cyc_cnt + 1;
    if (tick === 1'b1)       n_tick <= n_tick + 1;
    if (cfg_done === 1'b1)   n_done <= n_done + 1;
    if (snap_valid === 1'b1) begin n_sv <= n_sv + 1; sv_cyc <= cyc_cnt; end
    if (busy === 1'b1)       n_busy <= n_busy + 1;
    if (busy === 1'b1 && busy_d !== 1'b1) busy_rise_cyc <= cyc_cnt;
    busy_d <= busy;
  end

  int n_vec = 0, n_miss = 0;
  logic [18:0] exp_q [$];
  int m_ticks = 0;
  logic [31:0] m_snap = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Compares writes logged since base against exp_q; snapshot-trigger data is don't-care.
  task automatic check_log(input string tag, input int base);
    check({tag, " write count"}, wr_log.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size() && base + i < wr_log.size(); i++) begin
      if (exp_q[i][18:16] == 3'd4)
        check($sformatf("%s wr%0d addr", tag, i), 32'(wr_log[base+i][18:16]), 32'd4);
      else
        check($sformatf("%s wr%0d", tag, i), 32'(wr_log[base+i]), 32'(exp_q[i]));
    end
  endtask

  task automatic push_cfg(input logic [31:0] per, input bit ct, input bit ie);
    exp_q.push_back({3'd1, 16'h0008});
    exp_q.push_back({3'd2, per[15:0]});
    exp_q.push_back({3'd3, per[31:16]});
    exp_q.push_back({3'd1, 12'b0, 1'b0, 1'b1, ct, ie});
  endtask

  task automatic pulse_irq();
    irq_raise = 1'b1;
    @(negedge clk);
    irq_raise = 1'b0;
  endtask

  // All requests of one transaction land on the same edge; model orders them by priority.
  task automatic apply(input bit irq, input bit stp, input bit cfg, input bit snp,
                       input logic [31:0] per, input bit ct, input bit ie,
                       input logic [31:0] src, output int nwr);
    int base, t0, d0, s0;
    exp_q.delete();
    if (irq) exp_q.push_back({3'd0, 16'h0000});
    if (stp) exp_q.push_back({3'd1, 16'h0008});
    if (cfg) push_cfg(per, ct, ie);
    if (snp) exp_q.push_back({3'd4, 16'h0000});
    if (irq) m_ticks = (m_ticks + 1) % (1 << TW);
    if (snp) begin m_snap = src; snap_src = src; end
    base = wr_log.size(); t0 = n_tick; d0 = n_done; s0 = n_sv;
    cfg_period = per; cfg_cont = ct; cfg_irq_en = ie;
    irq_raise = irq; stop_req = stp; cfg_req = cfg; snap_req = snp;
    @(negedge clk);
    irq_raise = 1'b0; stop_req = 1'b0; cfg_req = 1'b0; snap_req = 1'b0;
    repeat (24) @(negedge clk);
    #1;
    nwr = wr_log.size() - base;
    check_log("txn", base);
    check("txn tick_count", 32'(tick_count), 32'(m_ticks));
    check("txn tick pulses", n_tick - t0, 32'(irq));
    check("txn cfg_done pulses", n_done - d0, 32'(cfg));
    check("txn snap_valid pulses", n_sv - s0, 32'(snp));
    check("txn snap_value", snap_value, m_snap);
    $display("txn irq=%0d stop=%0d cfg=%0d snap=%0d writes=%0d tick_count=%0d snap=0x%08h",
             irq, stp, cfg, snp, nwr, tick_count, snap_value);
  endtask

  typedef struct {
    bit irq; bit stp; bit cfg; bit snp;
    logic [31:0] per; bit ct; bit ie; logic [31:0] src;
    int exp_nwr; logic [31:0] exp_snap; int exp_ticks;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int base, t0, d0, b0, s0, nwr;

    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,          1, 32'h0,        1};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,          1, 32'h0,        1};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 1'b1, 1'b0, 32'h0,         4, 32'h0,        1};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'hDEADBEEF,   1, 32'hDEADBEEF, 1};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF0001, 1'b1, 1'b1, 32'h1,   7, 32'h1,        2};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'hCAFE0000,   2, 32'hCAFE0000, 3};

    // Reset state, then auto-configuration with INIT_PERIOD
    repeat (3) @(negedge clk);
    #1;
    check("reset chipselect", 32'(av_chipselect), 32'd0);
    check("reset write_n", 32'(av_write_n), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    check("reset tick_count", 32'(tick_count), 32'd0);
    check("reset snap_value", snap_value, 32'd0);
    base = wr_log.size(); b0 = n_busy; d0 = n_done;
    reset = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    exp_q.delete();
    push_cfg(32'd49999, 1'b1, 1'b1);
    check_log("autocfg", base);
    check("autocfg busy cycles", n_busy - b0, 32'd4);
    check("autocfg cfg_done pulses", n_done - d0, 32'd1);
    $display("autocfg: %0d writes, busy %0d cycles", wr_log.size() - base, n_busy - b0);

    // Level irq held until acknowledged gives exactly one tick
    base = wr_log.size(); t0 = n_tick;
    pulse_irq();
    repeat (10) @(negedge clk);
    #1;
    exp_q.delete();
    exp_q.push_back({3'd0, 16'h0000});
    check_log("irq", base);
    check("irq tick pulses", n_tick - t0, 32'd1);
    check("irq tick_count", 32'(tick_count), 32'd1);
    $display("irq: tick_count=%0d", tick_count);

    // Snapshot
    snap_src = 32'h1234ABCD;
    base = wr_log.size(); s0 = n_sv; b0 = n_busy;
    snap_req = 1'b1;
    @(negedge clk);
    snap_req = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    exp_q.delete();
    exp_q.push_back({3'd4, 16'h0000});
    check_log("snap", base);
    check("snap value", snap_value, 32'h1234ABCD);
    check("snap_valid pulses", n_sv - s0, 32'd1);
    check("snap busy cycles", n_busy - b0, 32'd4);
    check("snap latency", sv_cyc - busy_rise_cyc, 32'd4);
    $display("snap: value=0x%08h", snap_value);

    // cfg_req and irq arriving during a snapshot
    snap_src = 32'h0BADF00D;
    base = wr_log.size(); d0 = n_done;
    snap_req = 1'b1;
    @(negedge clk);
    snap_req = 1'b0;
    repeat (2) @(negedge clk);
    cfg_period = 32'h00020000; cfg_cont = 1'b0; cfg_irq_en = 1'b1;
    cfg_req = 1'b1; irq_raise = 1'b1;
    @(negedge clk);
    cfg_req = 1'b0; irq_raise = 1'b0;
    repeat (25) @(negedge clk);
    #1;
    exp_q.delete();
    exp_q.push_back({3'd4, 16'h0000});
    exp_q.push_back({3'd0, 16'h0000});
    push_cfg(32'h00020000, 1'b0, 1'b1);
    check_log("mixed", base);
    check("mixed snap value", snap_value, 32'h0BADF00D);
    check("mixed tick_count", 32'(tick_count), 32'd2);
    check("mixed cfg_done pulses", n_done - d0, 32'd1);
    $display("mixed: %0d writes", wr_log.size() - base);

    // tick_count wrap and clear/tick coincidence
    clear_ticks = 1'b1;
    @(negedge clk);
    clear_ticks = 1'b0;
    #1;
    check("clear tick_count", 32'(tick_count), 32'd0);
    for (int i = 0; i < 15; i++) begin
      pulse_irq();
      repeat (4) @(negedge clk);
    end
    #1;
    check("preset tick_count", 32'(tick_count), 32'd15);
    t0 = n_tick;
    pulse_irq();
    repeat (5) @(negedge clk);
    #1;
    check("wrap tick_count", 32'(tick_count), 32'd0);
    check("wrap tick pulses", n_tick - t0, 32'd1);
    for (int i = 0; i < 2; i++) begin
      pulse_irq();
      repeat (4) @(negedge clk);
    end
    #1;
    check("pre-clear tick_count", 32'(tick_count), 32'd2);
    t0 = n_tick;
    pulse_irq();
    @(negedge clk);
    clear_ticks = 1'b1;
    @(negedge clk);
    clear_ticks = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("clear-vs-tick tick_count", 32'(tick_count), 32'd0);
    check("clear-vs-tick tick pulses", n_tick - t0, 32'd1);
    $display("wrap/clear: tick_count=%0d", tick_count);

    // Reset while in CFG_PH with a snapshot also pending
    cfg_period = 32'h00001111; cfg_cont = 1'b1; cfg_irq_en = 1'b0;
    cfg_req = 1'b1; snap_req = 1'b1;
    @(negedge clk);
    cfg_req = 1'b0; snap_req = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("midcfg address", 32'(av_address), 32'd3);
    check("midcfg write_n", 32'(av_write_n), 32'd0);
    d0 = n_done;
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("rst chipselect", 32'(av_chipselect), 32'd0);
    check("rst write_n", 32'(av_write_n), 32'd1);
    check("rst busy", 32'(busy), 32'd0);
    check("rst cfg_done", 32'(n_done - d0), 32'd0);
    base = wr_log.size();
    reset = 1'b0;
    repeat (14) @(negedge clk);
    #1;
    exp_q.delete();
    push_cfg(32'd49999, 1'b1, 1'b1);
    check_log("post-reset", base);
    $display("reset-in-cfg: %0d writes after release", wr_log.size() - base);
    m_ticks = 0;
    m_snap  = 32'h0;

    // Table vectors
    foreach (tbl[i]) begin
      apply(tbl[i].irq, tbl[i].stp, tbl[i].cfg, tbl[i].snp, tbl[i].per, tbl[i].ct, tbl[i].ie,
            tbl[i].src, nwr);
      check($sformatf("tbl%0d writes", i), nwr, tbl[i].exp_nwr);
      check($sformatf("tbl%0d snap", i), snap_value, tbl[i].exp_snap);
      check($sformatf("tbl%0d ticks", i), 32'(tick_count), 32'(tbl[i].exp_ticks));
    end

    // Randomized request mixes
    for (int i = 0; i < 30; i++) begin
      apply(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, nwr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
